// File: rtl/core_types_pkg.sv
// Shared core types: word type, RAM handshake states and address-space widths.
package core_types_pkg;

  localparam int unsigned ADDR_SPACE_WIDTH      = 16;
  localparam int unsigned WORD_ADDR_SPACE_WIDTH = ADDR_SPACE_WIDTH - 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_responder_pkg.sv
// Constants and types local to the RAM responder.
package ram_responder_pkg;

  import core_types_pkg::*;

  // Default number of BUSY cycles before ACCESS.
  localparam int unsigned RAM_LATENCY = 2;

  // Latency counter width; covers LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

  // The FSM state register encodes directly to the ramstate output.
  typedef ramstate_t ram_responder_state_t;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word array with registered read data and no reset.
module ram_array
  import core_types_pkg::*;
#(
  parameter int unsigned DEPTH = 2**WORD_ADDR_SPACE_WIDTH,
  parameter int unsigned AW    = WORD_ADDR_SPACE_WIDTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH];
  word_t rdata_q;

  // Write and registered read; rdata holds its value until the next read.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata_q  <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// RAM request responder: FREE/BUSY/ACCESS/ERROR handshake with configurable latency.
module ram_responder
  import core_types_pkg::*;
  import ram_responder_pkg::*;
#(
  parameter int unsigned LATENCY   = RAM_LATENCY,
  parameter int unsigned MEM_WORDS = 2**WORD_ADDR_SPACE_WIDTH
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  word_t       ramstore,
  output word_t       ramload,
  output ramstate_t   ramstate
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  ram_responder_state_t             state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             ren_q, ren_d;
  logic                             wen_q, wen_d;
  logic [WORD_ADDR_SPACE_WIDTH-1:0] idx_q, idx_d;
  word_t                            store_q, store_d;
  logic                             rd_seen_q, rd_seen_d;

  logic                             req;
  logic                             illegal;
  logic                             changed;
  logic                             do_access;
  logic [WORD_ADDR_SPACE_WIDTH-1:0] idx_in;
  word_t                            arr_rdata;

  assign req     = ramREN | ramWEN;
  assign idx_in  = ramaddr[2 +: WORD_ADDR_SPACE_WIDTH];
  assign illegal = (ramREN & ramWEN)
                 | (ramaddr[31:ADDR_SPACE_WIDTH] != '0)
                 | (ramaddr[1:0] != '0);
  assign changed = (ramREN != ren_q) | (ramWEN != wen_q)
                 | (idx_in != idx_q) | (ramstore != store_q);

  // Next-state, counter reload/decrement and request latching.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    idx_d     = idx_q;
    store_d   = store_q;
    do_access = 1'b0;

    case (state_q)
      FREE, ERROR: begin
        if (!req) begin
          state_d = FREE;
        end else if (illegal) begin
          state_d = ERROR;
        end else if (LATENCY == 0) begin
          state_d   = ACCESS;
          do_access = 1'b1;
        end else begin
          state_d = BUSY;
          ren_d   = ramREN;
          wen_d   = ramWEN;
          idx_d   = idx_in;
          store_d = ramstore;
          cnt_d   = CNT_RELOAD;
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = FREE;
        end else if (illegal) begin
          state_d = ERROR;
        end else if (changed) begin
          ren_d   = ramREN;
          wen_d   = ramWEN;
          idx_d   = idx_in;
          store_d = ramstore;
          cnt_d   = CNT_RELOAD;
        end else if (cnt_q == '0) begin
          state_d   = ACCESS;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACCESS: state_d = FREE;
      default: state_d = FREE;
    endcase

    rd_seen_d = rd_seen_q | (do_access & ramREN);
  end

  // State, counter and latched request registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      idx_q     <= '0;
      store_q   <= '0;
      rd_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      idx_q     <= idx_d;
      store_q   <= store_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  // An access only fires when live inputs match the latch (or LATENCY=0),
  // so the live bus drives the array; nRST blocks accesses while in reset.
  ram_array #(
    .DEPTH (MEM_WORDS),
    .AW    (WORD_ADDR_SPACE_WIDTH)
  ) u_ram_array (
    .clk   (CLK),
    .we    (do_access & ramWEN & nRST),
    .re    (do_access & ramREN & nRST),
    .idx   (idx_in),
    .wdata (ramstore),
    .rdata (arr_rdata)
  );

  // The array read register has no reset; mask it until the first read.
  assign ramload  = rd_seen_q ? arr_rdata : '0;
  assign ramstate = state_q;

endmodule
